// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning the HI/LO pair
// Operands are latched on accept; the result is computed from them and committed when the countdown expires.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } mdu_op_t;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CW-1:0]    cnt;
    mdu_op_t          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign a_ext = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi, lo} + prod;

    assign a_neg  = is_signed & a_q[WIDTH-1];
    assign b_neg  = is_signed & b_q[WIDTH-1];
    assign a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
    assign b_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;

    always_comb begin
        quo = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem = a_neg ? (~r_mag + 1'b1) : r_mag;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end else if (is_signed && (a_q == MOST_NEG) && (b_q == '1)) begin
            quo = a_q;
            rem = '0;
        end
    end

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT, OP_MULTU: {res_hi, res_lo} = prod;
            OP_MADD, OP_MADDU: {res_hi, res_lo} = acc;
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (!busy && start) begin
            case (mdu_op_t'(op))
                OP_MTHI: hi <= A;
                OP_MTLO: lo <= A;
                default: begin
                    a_q  <= A;
                    b_q  <= B;
                    op_q <= mdu_op_t'(op);
                    cnt  <= (op == OP_DIV || op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
                    busy <= 1'b1;
                end
            endcase
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                hi   <= res_hi;
                lo   <= res_lo;
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mdu_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start cycle; returns at the falling edge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts remaining busy cycles (bounded) and checks the count.
    task automatic wait_busy(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, 64'(n), 64'(exp_cycles));
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check_hilo("reset", 32'h0, 32'h0);

        // mult -1 * 2; hi/lo must hold during busy
        issue(3'd0, 32'hFFFF_FFFF, 32'h2);
        check_hilo("mult_hold", 32'h0, 32'h0);
        wait_busy("mult_busy", 5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // back-to-back: issued in the first non-busy cycle
        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        wait_busy("multu_busy", 5);
        check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'h2);
        wait_busy("div_busy", 10);
        check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd2, 32'h7, 32'hFFFF_FFFE);
        wait_busy("div2_busy", 10);
        check_hilo("div_negb", 32'h0000_0001, 32'hFFFF_FFFD);

        issue(3'd3, 32'h7, 32'h0);
        wait_busy("divu0_busy", 10);
        check_hilo("divu_zero", 32'h7, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("divov_busy", 10);
        check_hilo("div_ovf", 32'h0, 32'h8000_0000);

        issue(3'd3, 32'd100, 32'd7);
        wait_busy("divu_busy", 10);
        check_hilo("divu", 32'd2, 32'd14);

        issue(3'd4, 32'h0, 32'h0);
        check("mthi_busy", {63'h0, busy}, 64'h0);
        check("mthi_hi", {32'h0, hi}, 64'h0);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0);
        check("mtlo_busy", {63'h0, busy}, 64'h0);
        check_hilo("mtlo", 32'h0, 32'hFFFF_FFFF);

        // maddu carries into hi; an mtlo arriving mid-flight must be dropped
        issue(3'd7, 32'h1, 32'h1);
        issue(3'd5, 32'h5, 32'h0);
        wait_busy("maddu_busy", 4);
        check_hilo("maddu", 32'h1, 32'h0);

        issue(3'd6, 32'hFFFF_FFFF, 32'h1);
        wait_busy("madd_busy", 5);
        check_hilo("madd", 32'h0, 32'hFFFF_FFFF);

        // reset on the third busy cycle aborts the multiply
        issue(3'd0, 32'h3, 32'h4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check_hilo("abort", 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        check("abort_late_busy", {63'h0, busy}, 64'h0);
        check_hilo("abort_late", 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the combinational ALU in the EX stage.
- Owns the HI/LO register pair and implements mult, multu, div, divu, madd, maddu, mthi and mtlo.
- Exposes a busy flag so the hazard unit can stall mfhi/mflo and any new MDU op until the result is committed.
- Width and latencies are parameters, so the same block serves 32-bit and narrower test builds.

Parameters:
- WIDTH, 32: operand width and HI/LO width.
- MULT_CYCLES, 5: cycles from accept to HI/LO commit for mult/multu/madd/maddu; must be ≥1.
- DIV_CYCLES, 10: cycles from accept to HI/LO commit for div/divu; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to execute op this cycle.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6=madd, 7=maddu.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- busy  output  1  operation in flight; HI/LO not yet final.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: one clock with reset=1 clears hi, lo and busy to 0 and the cycle counter to 0. Reset aborts any in-flight op with no commit. Reset has priority over start.
- Accept: start is sampled on a rising edge only when busy=0. start while busy=1 is ignored; no queueing, and the in-flight op is unaffected. The hazard unit must hold the instruction.
- mthi/mtlo:
  - Accepted on edge t; hi (or lo) = A, visible in cycle t+1.
  - busy stays 0.
- Multi-cycle ops:
  - On accept, A and B are latched and the counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy = (counter != 0). The counter decrements once per edge.
  - On the edge where the counter goes 1→0, hi/lo commit. busy falls in the same cycle the new hi/lo become visible.
  - With latency L and accept on edge t: busy=1 for cycles t+1..t+L, and hi/lo carry the new values from cycle t+L+1 onward.
  - hi/lo hold their old values throughout busy.
- Arithmetic, using the latched operands:
  - mult: signed 2·WIDTH product; hi = upper half, lo = lower half.
  - multu: same as mult, unsigned.
  - madd/maddu: {hi,lo} = {hi,lo} + product (signed/unsigned), modulo 2^(2·WIDTH). The {hi,lo} used is the value at commit time, which equals the value at accept because hi/lo cannot change while busy.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of A.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B=0): lo = all ones, hi = A. This is fixed for both div and divu; no trap.
  - Signed overflow (div with A = most-negative, B = all ones): lo = A, hi = 0.
- Back-to-back: a new start can be accepted in the first cycle busy=0, i.e. the cycle the previous result becomes visible. Throughput is one op per L+1 cycles.
- Output timing: no combinational path from start/op/A/B to busy, hi or lo; all outputs are registered.

Test Plan:
- Reset, then mult with A=0xFFFFFFFF (−1), B=2 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2 → hi=0x00000001, lo=0xFFFFFFFE.
- div with A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- divu with A=7, B=0 → lo=0xFFFFFFFF, hi=7. Then div with A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- Sequence:
  - mthi A=0, then mtlo A=0xFFFFFFFF.
  - maddu with A=1, B=1 → hi=1, lo=0, showing the carry into hi.
  - Mid-flight start(mtlo, A=5) while busy → ignored; lo is not 5 afterward.
- mult A=3, B=4 with reset asserted on the 3rd busy cycle → next cycle busy=0, hi=lo=0, and no later commit of 12.
